ascon_sigma_seq: RTL and testbench
==================================

# ascon_sigma_seq

Multi-cycle Ascon linear-diffusion sequencer. It accepts a full 320-bit Ascon state over a valid/ready handshake and applies the per-lane sigma function to lanes x0..x4, one 64-bit lane per cycle, using full 6-bit rotation amounts. It returns the diffused state over a second valid/ready handshake. It sits beside the RV32 sigma ISE datapath as the state-level engine that produces its reference results and feeds whole-permutation flows.

## Interface
Parameters:
- none (rotation table fixed by the Ascon specification)

Ports:
- g_clk  in  1  clock; all state changes on the rising edge
- g_rst  in  1  reset, synchronous, active-high
- in_valid  in  1  upstream state available
- in_ready  out  1  block can accept; high only in IDLE
- in_state  in  320  {x4,x3,x2,x1,x0}; lane i = bits [64i+63:64i]
- out_valid  out  1  diffused state available; high only in DONE
- out_ready  in  1  downstream accepts
- out_state  out  320  diffused state, same lane layout; held stable while out_valid=1
- done_cnt  out  16  completed-transfer count (present only with ASCON_SIGMA_SEQ_CNT_EN)

Reset is synchronous and active-high on g_rst, clocked by g_clk.

## Operation
- FSM states are IDLE, RUN, DONE. Lane counter lane[2:0]. State register st[319:0].
- IDLE:
  - in_ready=1.
  - On in_valid=1, load st from in_state, set lane=0, go to RUN.
- RUN:
  - Each cycle, replace lane `lane` of st with sigma_lane(x).
  - sigma_lane(x) = x ^ ror64(x,r0) ^ ror64(x,r1).
  - Rotation pairs (r0,r1): lane0 (19,28), lane1 (61,39), lane2 (1,6), lane3 (10,17), lane4 (7,41).
  - ror64 is a true 64-bit rotate right with a 6-bit amount. No truncation to 5 bits.
  - Each cycle, lane increments. When lane=4, go to DONE and reset lane to 0.
  - in_valid is ignored in RUN.
- DONE:
  - out_valid=1 and out_state=st.
  - On out_ready=1, go to IDLE.
  - No new accept in the same cycle.
- Lanes are independent. Processing order does not affect the result.
- Reset:
  - State becomes IDLE, lane=0, st=0.
  - After reset: in_ready=1, out_valid=0, out_state=0.
  - A g_rst during RUN or DONE discards the in-flight state. No output handshake occurs for it.
- out_state is undefined-free: it always equals st.

## Timing
- Input transfer happens on the edge where in_valid & in_ready are both high (cycle T).
- RUN occupies cycles T+1..T+5, with lanes 0..4 written at the ends of those cycles.
- out_valid is first high in cycle T+6, so latency is 6 cycles from accept to out_valid.
- If out_ready=1 in T+6, IDLE is reached at T+7. The earliest next accept is cycle T+7, giving 7 cycles per state at best.
- Backpressure: DONE holds indefinitely with out_valid and out_state stable.
- in_ready and out_valid are decoded from registered FSM state only. There is no combinational path from in_valid/out_ready to in_ready/out_valid.

## Configuration
- ASCON_SIGMA_SEQ_CNT_EN defined:
  - Adds port done_cnt[15:0], reset to 0.
  - Increments by 1 on each output handshake (out_valid & out_ready).
  - Wraps 0xFFFF -> 0x0000.
  - Is not cleared by anything except g_rst.
- Not defined: done_cnt port and counter logic are absent. Behaviour is otherwise identical.

## Test plan
- Reset then idle:
  - Assert g_rst 2 cycles, release -> in_ready=1, out_valid=0, out_state=0.
  - in_valid=0 for 10 cycles -> no state change.
- Zero state:
  - in_state=0, out_ready=1 -> out_valid high exactly 6 cycles after accept, out_state=0.
- Single-bit lanes:
  - x0=1, others 0 -> lane0 out=0x0000_2010_0000_0001, others 0.
  - x1=1 -> lane1 out=0x0000_0000_0200_0009.
  - x2=1 -> lane2 out=0x8400_0000_0000_0001.
  - Exercises rotations greater than 31.
- Backpressure:
  - Hold out_ready=0 for 20 cycles -> out_valid stays 1, out_state stable, in_ready=0.
  - in_valid pulses during this window are ignored.
- Reset mid-operation:
  - Assert g_rst at cycle T+3 of a transfer -> next cycle IDLE, out_valid never asserted for that transfer.
  - A following transfer produces the correct result.
- Counter (with ASCON_SIGMA_SEQ_CNT_EN):
  - 65537 back-to-back random transfers compared against the software sigma model -> all match.
  - done_cnt=0x0001 after the last transfer (wrap).

Source files
------------

// File: rtl/ascon_sigma_seq.sv
`default_nettype none
// ascon_sigma_seq: state-level Ascon sigma diffusion, one 64-bit lane per cycle.
// Optional completed-transfer counter enabled by ASCON_SIGMA_SEQ_CNT_EN.
module ascon_sigma_seq (
  input  logic         g_clk,
  input  logic         g_rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [319:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [319:0] out_state
`ifdef ASCON_SIGMA_SEQ_CNT_EN
  ,
  output logic [15:0]  done_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [2:0]    lane, lane_next;
  logic [319:0]  st, st_next;

  // Rotate through a doubled copy so the full 6-bit amount is honoured.
  function automatic logic [63:0] ror64(input logic [63:0] x, input logic [5:0] r);
    logic [127:0] d;
    d = {x, x} >> r;
    return d[63:0];
  endfunction

  function automatic logic [63:0] sigma_lane(input logic [63:0] x,
                                             input logic [5:0]  r0,
                                             input logic [5:0]  r1);
    return x ^ ror64(x, r0) ^ ror64(x, r1);
  endfunction

  always_ff @(posedge g_clk) begin
    if (g_rst) begin
      state <= IDLE;
      lane  <= 3'd0;
      st    <= '0;
    end else begin
      state <= state_next;
      lane  <= lane_next;
      st    <= st_next;
    end
  end

  always_comb begin
    state_next = state;
    lane_next  = lane;
    st_next    = st;
    case (state)
      IDLE: begin
        if (in_valid) begin
          st_next    = in_state;
          lane_next  = 3'd0;
          state_next = RUN;
        end
      end
      RUN: begin
        case (lane)
          3'd0: st_next[ 63:  0] = sigma_lane(st[ 63:  0], 6'd19, 6'd28);
          3'd1: st_next[127: 64] = sigma_lane(st[127: 64], 6'd61, 6'd39);
          3'd2: st_next[191:128] = sigma_lane(st[191:128], 6'd1,  6'd6);
          3'd3: st_next[255:192] = sigma_lane(st[255:192], 6'd10, 6'd17);
          3'd4: st_next[319:256] = sigma_lane(st[319:256], 6'd7,  6'd41);
          default: st_next = st;
        endcase
        if (lane == 3'd4) begin
          lane_next  = 3'd0;
          state_next = DONE;
        end else begin
          lane_next = lane + 3'd1;
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_state = st;

`ifdef ASCON_SIGMA_SEQ_CNT_EN
  always_ff @(posedge g_clk) begin
    if (g_rst)                       done_cnt <= 16'd0;
    else if (out_valid && out_ready) done_cnt <= done_cnt + 16'd1;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ascon_sigma_seq.sv
`default_nettype none
// Directed self-checking bench for ascon_sigma_seq.
module tb_ascon_sigma_seq;

  logic         g_clk = 1'b0;
  logic         g_rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [319:0] in_state = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [319:0] out_state;
`ifdef ASCON_SIGMA_SEQ_CNT_EN
  logic [15:0]  done_cnt;
  int           exp_cnt = 0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 g_clk = ~g_clk;

  ascon_sigma_seq dut (
    .g_clk     (g_clk),
    .g_rst     (g_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state)
`ifdef ASCON_SIGMA_SEQ_CNT_EN
    ,
    .done_cnt  (done_cnt)
`endif
  );

  typedef struct {
    logic [319:0] din;
    logic [319:0] dexp;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [319:0] got, input logic [319:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_cnt(input string name);
`ifdef ASCON_SIGMA_SEQ_CNT_EN
    check(name, {304'd0, done_cnt}, 320'(exp_cnt & 16'hFFFF));
`endif
  endtask

  // Full transfer with latency measurement; expects the block idle on entry.
  task automatic do_xfer(input string name, input logic [319:0] s, input logic [319:0] exp);
    int cyc;
    @(negedge g_clk);
    check({name, "_in_ready"}, {319'd0, in_ready}, 320'd1);
    in_state  = s;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(negedge g_clk);
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      @(negedge g_clk);
      cyc++;
    end
    check({name, "_latency"}, 320'(cyc), 320'd6);
    check({name, "_state"}, out_state, exp);
    out_ready = 1'b1;
    @(negedge g_clk);
    out_ready = 1'b0;
`ifdef ASCON_SIGMA_SEQ_CNT_EN
    exp_cnt++;
`endif
    check({name, "_back_idle"}, {318'd0, in_ready, out_valid}, 320'b10);
    check_cnt({name, "_cnt"});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{320'd0, 320'd0};
    vecs[1] = '{{256'd0, 64'h1}, {256'd0, 64'h0000_2010_0000_0001}};
    vecs[2] = '{{192'd0, 64'h1, 64'd0}, {192'd0, 64'h0000_0000_0200_0009, 64'd0}};
    vecs[3] = '{{128'd0, 64'h1, 128'd0}, {128'd0, 64'h8400_0000_0000_0001, 128'd0}};
    vecs[4] = '{{64'd0, 64'h1, 192'd0}, {64'd0, 64'h0040_8000_0000_0001, 192'd0}};
    vecs[5] = '{{64'h1, 256'd0}, {64'h0200_0000_0080_0001, 256'd0}};
    vecs[6] = '{{64'h1, 64'h1, 64'h1, 64'h1, 64'h1},
                {64'h0200_0000_0080_0001, 64'h0040_8000_0000_0001, 64'h8400_0000_0000_0001,
                 64'h0000_0000_0200_0009, 64'h0000_2010_0000_0001}};
    vecs[7] = '{{320{1'b1}}, {320{1'b1}}};
    vecs[8] = '{{64'h8000_0000_0000_0000, 192'd0, 64'h8000_0000_0000_0000},
                {64'h8100_0000_0040_0000, 192'd0, 64'h8000_1008_0000_0000}};

    // Reset and idle
    g_rst = 1'b1;
    repeat (2) @(posedge g_clk);
    @(negedge g_clk);
    g_rst = 1'b0;
    @(negedge g_clk);
    check("rst_in_ready", {319'd0, in_ready}, 320'd1);
    check("rst_out_valid", {319'd0, out_valid}, 320'd0);
    check("rst_out_state", out_state, 320'd0);
    check_cnt("rst_cnt");
    for (int i = 0; i < 10; i++) @(negedge g_clk);
    check("idle_hold", {318'd0, in_ready, out_valid}, 320'b10);
    check("idle_state", out_state, 320'd0);

    // Table-driven transfers
    for (int i = 0; i < 9; i++) do_xfer($sformatf("vec%0d", i), vecs[i].din, vecs[i].dexp);

    // Backpressure: DONE must hold and ignore in_valid pulses
    @(negedge g_clk);
    in_state = vecs[2].din;
    in_valid = 1'b1;
    @(negedge g_clk);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) @(negedge g_clk);
    check("bp_valid_start", {319'd0, out_valid}, 320'd1);
    for (int i = 0; i < 20; i++) begin
      check($sformatf("bp_hold%0d", i), {318'd0, in_ready, out_valid}, 320'b01);
      check($sformatf("bp_state%0d", i), out_state, vecs[2].dexp);
      in_valid = (i == 4 || i == 12);
      in_state = vecs[7].din;
      @(negedge g_clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge g_clk);
    out_ready = 1'b0;
`ifdef ASCON_SIGMA_SEQ_CNT_EN
    exp_cnt++;
`endif
    check("bp_release", {318'd0, in_ready, out_valid}, 320'b10);
    check_cnt("bp_cnt");
    for (int i = 0; i < 8; i++) @(negedge g_clk);
    check("bp_no_ghost", {318'd0, in_ready, out_valid}, 320'b10);

    // Reset in the middle of RUN
    in_state = vecs[6].din;
    in_valid = 1'b1;
    @(negedge g_clk);
    in_valid = 1'b0;
    @(negedge g_clk);
    @(negedge g_clk);
    g_rst = 1'b1;
    @(negedge g_clk);
    g_rst = 1'b0;
`ifdef ASCON_SIGMA_SEQ_CNT_EN
    exp_cnt = 0;
`endif
    check("mid_rst_idle", {318'd0, in_ready, out_valid}, 320'b10);
    check("mid_rst_state", out_state, 320'd0);
    check_cnt("mid_rst_cnt");
    begin
      int seen = 0;
      for (int i = 0; i < 10; i++) begin
        if (out_valid) seen++;
        @(negedge g_clk);
      end
      check("mid_rst_no_out", 320'(seen), 320'd0);
    end
    do_xfer("after_rst", vecs[8].din, vecs[8].dexp);

    // Back-to-back transfers to confirm throughput and counting
    do_xfer("b2b0", vecs[3].din, vecs[3].dexp);
    do_xfer("b2b1", vecs[5].din, vecs[5].dexp);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
